// File: rtl/st_video_pkg.sv
// Shared timing constants, resolution decode and per-mode video timing table
// for the shifter-facing video timing generator.
package st_video_pkg;

    localparam int unsigned HCNT_W  = 11;
    localparam int unsigned VCNT_W  = 9;
    localparam int unsigned ADDR_W  = 21;
    localparam int unsigned HT_W    = 12;
    localparam int unsigned VT_W    = 10;
    localparam int unsigned WORDS_W = 8;
    localparam int unsigned SLOT_W  = 4;

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        MED  = 2'd1,
        MONO = 2'd2
    } res_t;

    typedef struct packed {
        logic [HT_W-1:0]    h_total;
        logic [HT_W-1:0]    hsync;
        logic [HT_W-1:0]    de_start;
        logic [WORDS_W-1:0] words;
        logic [VT_W-1:0]    v_total;
        logic [VT_W-1:0]    vsync;
        logic [VT_W-1:0]    v_first;
        logic [VT_W-1:0]    v_lines;
    } vtiming_t;

    // Register encoding 3 is undefined on the shifter and behaves as low res.
    function automatic res_t res_decode(input logic [1:0] r);
        res_t d;
        case (r)
            2'd1:    d = MED;
            2'd2:    d = MONO;
            default: d = LOW;
        endcase
        return d;
    endfunction

    function automatic vtiming_t timing_for(input res_t r);
        vtiming_t t;
        if (r == MONO) begin
            t.h_total  = 12'd896;
            t.hsync    = 12'd64;
            t.de_start = 12'd160;
            t.words    = 8'd40;
            t.v_total  = 10'd501;
            t.vsync    = 10'd2;
            t.v_first  = 10'd34;
            t.v_lines  = 10'd400;
        end else begin
            t.h_total  = 12'd2048;
            t.hsync    = 12'd160;
            t.de_start = 12'd448;
            t.words    = 8'd80;
            t.v_total  = 10'd313;
            t.vsync    = 10'd3;
            t.v_first  = 10'd63;
            t.v_lines  = 10'd200;
        end
        return t;
    endfunction

endpackage

// File: rtl/st_video_hv_counter.sv
// Horizontal/vertical position counters; latches the resolution once per
// frame and flags the frame-start position (0,0).
module st_video_hv_counter
    import st_video_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        res,
    input  logic [HT_W-1:0]   h_total,
    input  logic [VT_W-1:0]   v_total,
    output logic [HCNT_W-1:0] hcnt,
    output logic [VCNT_W-1:0] vcnt,
    output res_t              res_q,
    output logic              frame_start_c
);

    logic h_last;
    logic v_last;

    assign frame_start_c = (hcnt == '0) && (vcnt == '0);
    assign h_last        = HT_W'(hcnt) >= (h_total - HT_W'(1));
    assign v_last        = VT_W'(vcnt) >= (v_total - VT_W'(1));

    // res_q only moves at (0,0), so the limits never shrink under a live count.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt  <= '0;
            vcnt  <= '0;
            res_q <= res_decode(res);
        end else begin
            if (frame_start_c) begin
                res_q <= res_decode(res);
            end
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + VCNT_W'(1);
            end else begin
                hcnt <= hcnt + HCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/st_video_timing.sv
// Video timing and fetch-address generator feeding the shifter: de, load_n,
// syncs and video RAM word address, all registered one clock after decode.
module st_video_timing
    import st_video_pkg::*;
(
    input  logic              CLOCK_32,
    input  logic              reset,
    input  logic [1:0]        res,
    input  logic [ADDR_W-1:0] video_base,
    output logic              de,
    output logic              load_n,
    output logic              hsync_n,
    output logic              vsync_n,
    output logic [ADDR_W-1:0] vid_addr
);

    logic [HCNT_W-1:0] hcnt;
    logic [VCNT_W-1:0] vcnt;
    res_t              res_q;
    logic              frame_start_c;
    vtiming_t          tim;

    logic [HT_W-1:0]   hpos;
    logic [VT_W-1:0]   vpos;
    logic [HT_W-1:0]   de_end;
    logic [SLOT_W-1:0] phase;
    logic              visible;
    logic              de_c;
    logic              load_c;
    logic              step_c;
    logic              hsync_c;
    logic              vsync_c;

    assign tim = timing_for(res_q);

    st_video_hv_counter u_hv (
        .clk           (CLOCK_32),
        .reset         (reset),
        .res           (res),
        .h_total       (tim.h_total),
        .v_total       (tim.v_total),
        .hcnt          (hcnt),
        .vcnt          (vcnt),
        .res_q         (res_q),
        .frame_start_c (frame_start_c)
    );

    // Decode window and 16-clock fetch slot; load is the last quarter of a slot.
    always_comb begin
        hpos    = HT_W'(hcnt);
        vpos    = VT_W'(vcnt);
        de_end  = tim.de_start + {tim.words, 4'b0000};
        phase   = SLOT_W'(hpos - tim.de_start);
        visible = (vpos >= tim.v_first) && (vpos < (tim.v_first + tim.v_lines));
        de_c    = visible && (hpos >= tim.de_start) && (hpos < de_end);
        load_c  = de_c && (phase[SLOT_W-1:SLOT_W-2] == 2'b11);
        step_c  = de_c && (phase == '1);
        hsync_c = hpos < tim.hsync;
        vsync_c = vpos < tim.vsync;
    end

    // Frame-start reload wins over a slot-end increment on the same edge.
    always_ff @(posedge CLOCK_32) begin
        if (reset) begin
            de       <= 1'b0;
            load_n   <= 1'b1;
            hsync_n  <= 1'b1;
            vsync_n  <= 1'b1;
            vid_addr <= video_base;
        end else begin
            de      <= de_c;
            load_n  <= ~load_c;
            hsync_n <= ~hsync_c;
            vsync_n <= ~vsync_c;
            if (frame_start_c) begin
                vid_addr <= video_base;
            end else if (step_c) begin
                vid_addr <= vid_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: doc/st_video_timing.md
# st_video_timing

Video timing and fetch-address generator sitting directly upstream of the shifter. From the 32 MHz clock it produces the shifter's `de` and active-low `load` strobes, horizontal and vertical sync, and the video RAM word address whose data must be valid on the shifter data bus during each load. Resolution and screen base are sampled once per frame, so mid-frame register writes never tear a frame.

## Interface
- `NONE` — no parameters; all timing constants live in `st_video_pkg`.

- `CLOCK_32` in 1 — 32 MHz system clock; all logic on rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `res` in 2 — resolution from the shifter register at 0x10: 0 low, 1 medium, 2 mono, 3 treated as low.
- `video_base` in 21 — screen base as a word address (byte address bits 21:1).
- `de` out 1 — display enable to shifter.
- `load_n` out 1 — active-low word load strobe to shifter.
- `hsync_n` out 1 — active-low horizontal sync.
- `vsync_n` out 1 — active-low vertical sync.
- `vid_addr` out 21 — word address of the current or next fetch.

## Operation
- `hcnt` counts 0..H_TOTAL-1; `vcnt` increments at `hcnt` wrap, counting 0..V_TOTAL-1 and then wrapping.
- Frame start is `hcnt`=0 and `vcnt`=0. At frame start, `res_q` <= `res` (3 maps to 0) and `vid_addr` <= `video_base`.
- Timing per `res_q`:
  - Low/medium: H_TOTAL 2048, HSYNC 160, DE_START 448, WORDS 80, V_TOTAL 313, VSYNC 3, V_FIRST 63, V_LINES 200.
  - Mono: H_TOTAL 896, HSYNC 64, DE_START 160, WORDS 40, V_TOTAL 501, VSYNC 2, V_FIRST 34, V_LINES 400.
- `hsync_n` = 0 while `hcnt` < HSYNC.
- `vsync_n` = 0 while `vcnt` < VSYNC.
- Visible line: V_FIRST ≤ `vcnt` < V_FIRST+V_LINES.
- `de` = 1 on a visible line while DE_START ≤ `hcnt` < DE_START + 16·WORDS. Each 16-clock slot fetches one word.
- Slot phase: p = (`hcnt` − DE_START) mod 16.
  - `load_n` = 0 while `de` and p ∈ 12..15, i.e. a 4-clock-low, 16-clock-period strobe.
  - The first load falls 12 clocks after the `de` rise.
  - The last load ends exactly at the `de` fall.
- `vid_addr` increments by 1 on the clock where p = 15 within `de`. It wraps modulo 2^21. It holds otherwise, including across lines, so line N+1 continues from line N.
- No loads occur outside `de`; no partial slots.

## Timing
- All outputs are registered. Each output at edge t+1 reflects the counter state at edge t, giving a fixed 1-clock latency for every output.
- Reset (synchronous, checked first every edge):
  - `hcnt` = `vcnt` = 0, `res_q` <= `res`, `vid_addr` <= `video_base`.
  - `de` = 0, `load_n` = 1, `hsync_n` = 1, `vsync_n` = 1.
  - The first edge after reset release is treated as frame start.
- Reset mid-line or mid-load: outputs return to reset values on the next edge. A truncated load strobe is acceptable.
- `res` change mid-frame: ignored until the next frame start. `video_base` change mid-frame: same.
- Simultaneous `hcnt` wrap and `vcnt` wrap: frame-start sampling takes priority, so `vid_addr` reloads and does not increment.
- Counter widths: `hcnt` 11 bits, `vcnt` 9 bits. No counter value exceeds H_TOTAL−1 or V_TOTAL−1 after a resolution switch. Both counters reset to 0 at frame start, so there is no overflow path.

## Structure
- `st_video_pkg`:
  - `res_t` enum (LOW, MED, MONO).
  - `vtiming_t` struct holding H_TOTAL, HSYNC, DE_START, WORDS, V_TOTAL, VSYNC, V_FIRST, V_LINES.
  - Function `timing_for(res_t)`.
- Sub-module `st_video_hv_counter`:
  - Owns `hcnt`, `vcnt`, `res_q` and the frame-start pulse.
  - Top level decodes sync, `de`, `load_n` and the address counter.

## Test plan
- Reset with `res`=0 and `video_base`=0x01000, run one frame:
  - `hsync_n` is low for 160 clocks every 2048 clocks.
  - `vsync_n` is low for 3 lines.
  - 200 lines carry `de`, each 1280 clocks long.
  - `vid_addr` ends at 0x01000 + 16000 = 0x04E80.
- Single visible line, low res: `de` rises at hcnt-derived clock 449. The first `load_n` fall is 12 clocks later, and there are exactly 80 load pulses, each 4 clocks low with 16-clock period.
- Mono (`res`=2) frame: 400 `de` lines, 40 loads per line, line period 896 clocks, and `vid_addr` advances by 16000 per frame.
- Write `res`=2 mid-frame in low res: the current frame completes with 2048-clock lines, and the switch to 896-clock lines happens exactly at the next frame start.
- `video_base` = 0x1FFFF8 in low res: `vid_addr` wraps through 0x000000 after 8 loads, with no glitch on `load_n`.
- Assert `reset` during the 3rd clock of a `load_n` low pulse: the next edge has `load_n` = 1, `de` = 0, and `vid_addr` = `video_base`.
